// File: rtl/i2s_rx_master_axis.sv
// I2S / left-justified receiver that drives SCK and WS and queues stereo words onto AXI-Stream.
// Define I2S_RX_SIGN_EXT_EN for right-aligned, sign-extended samples (default: MSB-aligned, zero-filled).
module i2s_rx_master_axis #(
    parameter int DATA_WIDTH  = 32,
    parameter int SAMPLE_BITS = 24,
    parameter int SLOT_BITS   = 32,
    parameter int SCK_DIV     = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int I2S_MODE    = 1
) (
    input  logic                        M_AXIS_ACLK,
    input  logic                        M_AXIS_ARESETN,
    input  logic                        enable,
    input  logic                        sd,
    output logic                        sck,
    output logic                        ws,
    output logic [DATA_WIDTH-1:0]       M_AXIS_TDATA,
    output logic                        M_AXIS_TVALID,
    input  logic                        M_AXIS_TREADY,
    output logic                        M_AXIS_TLAST,
    output logic                        ovf,
    input  logic                        ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    // state  | meaning
    // S_IDLE | divider, bit counter, sck, ws and shift register held at zero
    // S_RUN  | sck/ws generated, sd sampled on sck rising edges

    localparam int DIV_W = $clog2(SCK_DIV);
    localparam int BIT_W = $clog2(SLOT_BITS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(SCK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF     = DIV_W'(SCK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_PRE_RISE = DIV_W'(SCK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] CAP_LAST     = BIT_W'(SAMPLE_BITS - 1 + I2S_MODE);
    localparam logic [LW-1:0]    LVL_FULL     = LW'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state, state_nxt;

    logic [DIV_W-1:0]       div, div_nxt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [SAMPLE_BITS-1:0] shreg, cap_word;
    logic [DATA_WIDTH-1:0]  fmt_word, push_data;
    logic                   fall_evt, rise_evt, in_window;
    logic                   push_pend, push_last;

    logic [DATA_WIDTH:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [LW-1:0]          level;
    logic                   full, pop, push_ok, drop;

    assign fall_evt  = (state == S_RUN) && (div == DIV_LAST);
    assign rise_evt  = (state == S_RUN) && (div == DIV_PRE_RISE);
    assign in_window = (bit_cnt <= CAP_LAST) && ((I2S_MODE == 0) || (bit_cnt != '0));
    assign cap_word  = {shreg[SAMPLE_BITS-2:0], sd};
    assign div_nxt   = (state == S_RUN && !fall_evt) ? div + 1'b1 : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable) state_nxt = S_RUN;
            S_RUN:   if (!enable && fall_evt) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
`ifdef I2S_RX_SIGN_EXT_EN
        fmt_word = {DATA_WIDTH{cap_word[SAMPLE_BITS-1]}};
        fmt_word[SAMPLE_BITS-1:0] = cap_word;
`else
        fmt_word = '0;
        fmt_word[DATA_WIDTH-1 -: SAMPLE_BITS] = cap_word;
`endif
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // sck is registered from the next divider value so it always equals (div >= SCK_DIV/2).
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            div       <= '0;
            sck       <= 1'b0;
            ws        <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            push_pend <= 1'b0;
            push_data <= '0;
            push_last <= 1'b0;
        end else begin
            div       <= div_nxt;
            sck       <= (div_nxt >= DIV_HALF);
            push_pend <= 1'b0;
            if (state_nxt == S_IDLE) begin
                bit_cnt <= '0;
                ws      <= 1'b0;
                shreg   <= '0;
            end else begin
                if (fall_evt) begin
                    bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) ws <= ~ws;
                end
                if (rise_evt && in_window) begin
                    shreg <= cap_word;
                    if (bit_cnt == CAP_LAST) begin
                        push_pend <= 1'b1;
                        push_data <= fmt_word;
                        push_last <= ws;
                    end
                end
            end
        end
    end

    assign M_AXIS_TVALID = (level != '0);
    assign full          = (level == LVL_FULL);
    assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
    assign push_ok       = push_pend && (!full || pop);
    assign drop          = push_pend && full && !pop;
    assign fifo_level    = level;
    assign {M_AXIS_TLAST, M_AXIS_TDATA} = M_AXIS_TVALID ? mem[rd_ptr] : '0;

    // When full, a simultaneous pop frees the head slot that the push overwrites.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {push_last, push_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_master_axis.sv
// Bench: two receivers (I2S and left-justified) fed by a behavioural codec that follows the
// observed sck/ws framing; words are checked against a table and a slot-indexed reference.
module tb_i2s_rx_master_axis;
    localparam int DW    = 32;
    localparam int SB    = 24;
    localparam int SLOT  = 32;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int LVW   = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic tready = 1'b0;
    logic ovf_clr = 1'b0;
    logic sd [2];
    logic sck [2];
    logic ws [2];
    logic tvalid [2];
    logic tlast [2];
    logic ovf [2];
    logic [DW-1:0]  tdata [2];
    logic [LVW-1:0] level [2];

    int n_assert = 0;
    int n_fail = 0;
    logic [SB-1:0] slot_words [64];
    logic [DW:0] got0 [$];
    logic [DW:0] got1 [$];
    bit codec_rst = 1'b0;

    typedef struct {
        logic [SB-1:0] left;
        logic [SB-1:0] right;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;

    i2s_rx_master_axis #(.DATA_WIDTH(DW), .SAMPLE_BITS(SB), .SLOT_BITS(SLOT), .SCK_DIV(DIV),
                         .FIFO_DEPTH(DEPTH), .I2S_MODE(1)) u_dut_i2s (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .enable(enable), .sd(sd[0]),
        .sck(sck[0]), .ws(ws[0]), .M_AXIS_TDATA(tdata[0]), .M_AXIS_TVALID(tvalid[0]),
        .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tlast[0]), .ovf(ovf[0]), .ovf_clr(ovf_clr),
        .fifo_level(level[0]));

    i2s_rx_master_axis #(.DATA_WIDTH(DW), .SAMPLE_BITS(SB), .SLOT_BITS(SLOT), .SCK_DIV(DIV),
                         .FIFO_DEPTH(DEPTH), .I2S_MODE(0)) u_dut_lj (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .enable(enable), .sd(sd[1]),
        .sck(sck[1]), .ws(ws[1]), .M_AXIS_TDATA(tdata[1]), .M_AXIS_TVALID(tvalid[1]),
        .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tlast[1]), .ovf(ovf[1]), .ovf_clr(ovf_clr),
        .fifo_level(level[1]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_word(input logic [SB-1:0] w);
        logic [DW-1:0] r;
`ifdef I2S_RX_SIGN_EXT_EN
        r = DW'(w);
        if (w[SB-1]) r = r - (DW'(1) << SB);
`else
        r = DW'(w) << (DW - SB);
`endif
        return r;
    endfunction

    // Codec: slot position = sck falls since the last ws change; data bit k goes out at position k+mode.
    initial begin : codec
        int pos [2];
        int slot [2];
        logic p_sck [2];
        logic p_ws [2];
        for (int d = 0; d < 2; d++) begin
            pos[d] = 0; slot[d] = 0; p_sck[d] = 1'b0; p_ws[d] = 1'b0; sd[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                int j;
                if (codec_rst) begin
                    pos[d] = 0; slot[d] = 0;
                end else if (ws[d] !== p_ws[d]) begin
                    pos[d] = 0; slot[d] = slot[d] + 1;
                end else if (p_sck[d] === 1'b1 && sck[d] === 1'b0) begin
                    pos[d] = pos[d] + 1;
                end
                p_sck[d] = sck[d];
                p_ws[d]  = ws[d];
                j = pos[d] - ((d == 0) ? 1 : 0);
                if (j >= 0 && j < SB && slot[d] < 64) sd[d] = slot_words[slot[d]][SB-1-j];
                else sd[d] = 1'($urandom);
            end
            codec_rst = 1'b0;
        end
    end

    initial begin : monitor
        logic hold [2];
        logic [DW:0] held [2];
        for (int d = 0; d < 2; d++) begin hold[d] = 1'b0; held[d] = '0; end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    hold[d] = 1'b0;
                end else begin
                    if (hold[d])
                        check($sformatf("hold_stable_d%0d", d), 64'({tvalid[d], tlast[d], tdata[d]}),
                              64'({1'b1, held[d]}));
                    if (tvalid[d] && tready) begin
                        if (d == 0) got0.push_back({tlast[d], tdata[d]});
                        else        got1.push_back({tlast[d], tdata[d]});
                    end
                    hold[d] = tvalid[d] && !tready;
                    held[d] = {tlast[d], tdata[d]};
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart_codec();
        codec_rst = 1'b1;
        tick();
    endtask

    task automatic stop_run();
        enable = 1'b0;
        repeat (3 * DIV) tick();
    endtask

    task automatic clear_q();
        got0.delete();
        got1.delete();
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? got0.size() : got1.size();
    endfunction

    task automatic wait_words(input int n, input int budget, input bit rnd);
        int c = 0;
        while ((got0.size() < n || got1.size() < n) && c < budget) begin
            tick();
            if (rnd) tready = 1'($urandom);
            c++;
        end
        check($sformatf("wait_%0d_words", n), 64'(c < budget), 64'(1));
    endtask

    task automatic cmp_word(input int d, input int k, input logic [DW-1:0] exp_data,
                            input logic exp_last, input string tag);
        logic [DW:0] g;
        if (q_size(d) <= k) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s_d%0d_w%0d: word missing, expected %h", tag, d, k, exp_data);
            return;
        end
        g = (d == 0) ? got0[k] : got1[k];
        check($sformatf("%s_d%0d_w%0d_data", tag, d, k), 64'(g[DW-1:0]), 64'(exp_data));
        check($sformatf("%s_d%0d_w%0d_last", tag, d, k), 64'(g[DW]), 64'(exp_last));
    endtask

    task automatic measure(input int d, input bit use_ws, output int per);
        logic prev, cur;
        int c;
        per = -1;
        prev = use_ws ? ws[d] : sck[d];
        cur = prev;
        c = 0;
        while (c < 1000) begin
            @(negedge clk);
            cur = use_ws ? ws[d] : sck[d];
            c++;
            if (cur && !prev) break;
            prev = cur;
        end
        if (c >= 1000) return;
        c = 0;
        prev = cur;
        while (c < 1000) begin
            @(negedge clk);
            cur = use_ws ? ws[d] : sck[d];
            c++;
            if (cur && !prev) begin
                per = c;
                return;
            end
            prev = cur;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_sck_d%0d", tag, d), 64'(sck[d]), 64'(0));
            check($sformatf("%s_ws_d%0d", tag, d), 64'(ws[d]), 64'(0));
            check($sformatf("%s_tvalid_d%0d", tag, d), 64'(tvalid[d]), 64'(0));
            check($sformatf("%s_tdata_d%0d", tag, d), 64'(tdata[d]), 64'(0));
            check($sformatf("%s_tlast_d%0d", tag, d), 64'(tlast[d]), 64'(0));
            check($sformatf("%s_ovf_d%0d", tag, d), 64'(ovf[d]), 64'(0));
            check($sformatf("%s_level_d%0d", tag, d), 64'(level[d]), 64'(0));
        end
    endtask

    task automatic randomize_words();
        for (int s = 0; s < 64; s++) slot_words[s] = SB'($urandom);
    endtask

    initial begin : main
        int per;
        bit seen;
`ifdef I2S_RX_SIGN_EXT_EN
        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 32'hFFA5A5A5, 32'h005A5A5A};
        vecs[1] = '{24'h800001, 24'h7FFFFF, 32'hFF800001, 32'h007FFFFF};
        vecs[2] = '{24'hFFFFFF, 24'h000000, 32'hFFFFFFFF, 32'h00000000};
        vecs[3] = '{24'h123456, 24'hFEDCBA, 32'h00123456, 32'hFFFEDCBA};
`else
        vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 32'hA5A5A500, 32'h5A5A5A00};
        vecs[1] = '{24'h800001, 24'h7FFFFF, 32'h80000100, 32'h7FFFFF00};
        vecs[2] = '{24'hFFFFFF, 24'h000000, 32'hFFFFFF00, 32'h00000000};
        vecs[3] = '{24'h123456, 24'hFEDCBA, 32'h12345600, 32'hFEDCBA00};
`endif
        randomize_words();

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            clear_q();
            slot_words[0] = vecs[i].left;
            slot_words[1] = vecs[i].right;
            restart_codec();
            tready = 1'b1;
            enable = 1'b1;
            wait_words(2, 600, 1'b0);
            stop_run();
            for (int d = 0; d < 2; d++) begin
                cmp_word(d, 0, vecs[i].exp_l, 1'b0, $sformatf("vec%0d", i));
                cmp_word(d, 1, vecs[i].exp_r, 1'b1, $sformatf("vec%0d", i));
                check($sformatf("vec%0d_count_d%0d", i, d), 64'(q_size(d)), 64'(2));
            end
        end

        clear_q();
        restart_codec();
        enable = 1'b1;
        for (int d = 0; d < 2; d++) begin
            measure(d, 1'b0, per);
            check($sformatf("sck_period_d%0d", d), 64'(per), 64'(DIV));
            measure(d, 1'b1, per);
            check($sformatf("ws_period_d%0d", d), 64'(per), 64'(2 * SLOT * DIV));
        end
        tick();
        stop_run();

        for (int r = 0; r < 3; r++) begin
            clear_q();
            randomize_words();
            restart_codec();
            enable = 1'b1;
            wait_words(8, 4000, 1'b1);
            enable = 1'b0;
            tready = 1'b1;
            repeat (40) tick();
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < q_size(d) && k < 64; k++)
                    cmp_word(d, k, model_word(slot_words[k]), 1'(k % 2), $sformatf("rand%0d", r));
                check($sformatf("rand%0d_ovf_d%0d", r, d), 64'(ovf[d]), 64'(0));
            end
        end

        clear_q();
        randomize_words();
        restart_codec();
        tready = 1'b0;
        enable = 1'b1;
        repeat (704) tick();
        enable = 1'b0;
        repeat (3 * DIV) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("full_level_d%0d", d), 64'(level[d]), 64'(DEPTH));
            check($sformatf("full_ovf_d%0d", d), 64'(ovf[d]), 64'(1));
            check($sformatf("full_tvalid_d%0d", d), 64'(tvalid[d]), 64'(1));
            check($sformatf("full_head_d%0d", d), 64'(tdata[d]), 64'(model_word(slot_words[0])));
            check($sformatf("full_head_last_d%0d", d), 64'(tlast[d]), 64'(0));
        end
        tready = 1'b1;
        repeat (10) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("drain_count_d%0d", d), 64'(q_size(d)), 64'(DEPTH));
            for (int k = 0; k < DEPTH; k++)
                cmp_word(d, k, model_word(slot_words[k]), 1'(k % 2), "drain");
            check($sformatf("drain_ovf_sticky_d%0d", d), 64'(ovf[d]), 64'(1));
            check($sformatf("drain_level_d%0d", d), 64'(level[d]), 64'(0));
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        for (int d = 0; d < 2; d++)
            check($sformatf("ovf_clr_d%0d", d), 64'(ovf[d]), 64'(0));

        clear_q();
        randomize_words();
        restart_codec();
        tready = 1'b1;
        enable = 1'b1;
        repeat (42) tick();
        enable = 1'b0;
        repeat (DIV) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("stop_sck_d%0d", d), 64'(sck[d]), 64'(0));
            check($sformatf("stop_ws_d%0d", d), 64'(ws[d]), 64'(0));
        end
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (sck[0] || sck[1] || ws[0] || ws[1]) seen = 1'b1;
        end
        check("stop_quiet", 64'(seen), 64'(0));
        for (int d = 0; d < 2; d++) begin
            check($sformatf("stop_no_partial_d%0d", d), 64'(q_size(d)), 64'(0));
            check($sformatf("stop_level_d%0d", d), 64'(level[d]), 64'(0));
        end
        restart_codec();
        enable = 1'b1;
        wait_words(2, 600, 1'b0);
        stop_run();
        for (int d = 0; d < 2; d++) begin
            cmp_word(d, 0, model_word(slot_words[0]), 1'b0, "reenable");
            cmp_word(d, 1, model_word(slot_words[1]), 1'b1, "reenable");
        end

        clear_q();
        randomize_words();
        restart_codec();
        tready = 1'b0;
        enable = 1'b1;
        repeat (300) tick();
        for (int d = 0; d < 2; d++)
            check($sformatf("pre_reset_level_d%0d", d), 64'(level[d]), 64'(2));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        codec_rst = 1'b1;
        repeat (2) tick();
        tready = 1'b1;
        rst_n = 1'b1;
        wait_words(2, 600, 1'b0);
        stop_run();
        for (int d = 0; d < 2; d++) begin
            cmp_word(d, 0, model_word(slot_words[0]), 1'b0, "post_reset");
            cmp_word(d, 1, model_word(slot_words[1]), 1'b1, "post_reset");
            check($sformatf("post_reset_count_d%0d", d), 64'(q_size(d)), 64'(2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
